// File: rtl/sva_window_monitor.sv
// Hardware checker for $rose(trig) |-> ##[MIN_DLY:MAX_DLY] resp, disable iff (disable_i).
// Tracks up to DEPTH overlapping attempts in age-counting slots; all outputs are registered.
module sva_window_monitor #(
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 10,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         trig,
  input  logic                         resp,
  input  logic                         disable_i,
  output logic [$clog2(DEPTH+1)-1:0]   pass_o,
  output logic [$clog2(DEPTH+1)-1:0]   fail_o,
  output logic                         overflow_o,
  output logic [$clog2(DEPTH+1)-1:0]   pending_o,
  output logic [CNT_W-1:0]             pass_total_o,
  output logic [CNT_W-1:0]             fail_total_o
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(MAX_DLY+1);
  localparam int SW = ((CNT_W > CW) ? CNT_W : CW) + 1;
  localparam logic [AW-1:0] MIN_A = AW'(MIN_DLY);
  localparam logic [AW-1:0] MAX_A = AW'(MAX_DLY);
  localparam logic [SW-1:0] SAT   = SW'({CNT_W{1'b1}});

  logic             trig_prev;
  logic [DEPTH-1:0] valid;
  logic [AW-1:0]    age [DEPTH];

  logic             rose;
  logic [DEPTH-1:0] valid_n;
  logic [AW-1:0]    age_n [DEPTH];
  logic [AW-1:0]    a;
  logic [CW-1:0]    pass_n;
  logic [CW-1:0]    fail_n;
  logic [CW-1:0]    pend_n;
  logic             ovf_n;
  logic             alloc_done;
  logic [SW-1:0]    psum;
  logic [SW-1:0]    fsum;
  logic [CNT_W-1:0] ptot_n;
  logic [CNT_W-1:0] ftot_n;

  always_comb begin
    rose       = trig & ~trig_prev;
    valid_n    = '0;
    a          = '0;
    pass_n     = '0;
    fail_n     = '0;
    pend_n     = '0;
    ovf_n      = 1'b0;
    alloc_done = 1'b0;
    for (int i = 0; i < DEPTH; i++) age_n[i] = age[i];

    if (!disable_i) begin
      // Resolve live attempts first so a slot freed this edge can take the new trigger.
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i]) begin
          a = age[i] + AW'(1);
          if (resp && (a >= MIN_A)) begin
            pass_n = pass_n + CW'(1);
          end else if (a == MAX_A) begin
            fail_n = fail_n + CW'(1);
          end else begin
            valid_n[i] = 1'b1;
            age_n[i]   = a;
          end
        end
      end
      if (rose) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!alloc_done && !valid_n[i]) begin
            valid_n[i] = 1'b1;
            age_n[i]   = '0;
            alloc_done = 1'b1;
          end
        end
        ovf_n = ~alloc_done;
      end
    end

    for (int i = 0; i < DEPTH; i++) pend_n = pend_n + CW'(valid_n[i]);

    // Counts are zero on a disable edge, so the totals hold without a special case.
    psum   = SW'(pass_total_o) + SW'(pass_n);
    fsum   = SW'(fail_total_o) + SW'(fail_n);
    ptot_n = (psum > SAT) ? {CNT_W{1'b1}} : psum[CNT_W-1:0];
    ftot_n = (fsum > SAT) ? {CNT_W{1'b1}} : fsum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_prev    <= 1'b0;
      valid        <= '0;
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
      pass_o       <= '0;
      fail_o       <= '0;
      overflow_o   <= 1'b0;
      pending_o    <= '0;
      pass_total_o <= '0;
      fail_total_o <= '0;
    end else begin
      trig_prev    <= trig;
      valid        <= valid_n;
      for (int i = 0; i < DEPTH; i++) age[i] <= age_n[i];
      pass_o       <= pass_n;
      fail_o       <= fail_n;
      overflow_o   <= ovf_n;
      pending_o    <= pend_n;
      pass_total_o <= ptot_n;
      fail_total_o <= ftot_n;
    end
  end

endmodule

// File: tb/tb_sva_window_monitor.sv
// Self-checking bench for sva_window_monitor: three parameterisations driven in lockstep,
// checked every cycle against an attempt-list model, plus directed scenarios with literal values.
module tb_sva_window_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trig = 1'b0;
  logic resp = 1'b0;
  logic disable_i = 1'b0;

  always #5 clk = ~clk;

  // A: defaults.  B: same window, 2-bit totals.  C: window [3:5], two slots.
  logic [2:0]  a_pass, a_fail, a_pend;
  logic        a_ov;
  logic [15:0] a_tp, a_tf;
  logic [2:0]  b_pass, b_fail, b_pend;
  logic        b_ov;
  logic [1:0]  b_tp, b_tf;
  logic [1:0]  c_pass, c_fail, c_pend;
  logic        c_ov;
  logic [7:0]  c_tp, c_tf;

  sva_window_monitor #(.MIN_DLY(1), .MAX_DLY(10), .DEPTH(4), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .trig(trig), .resp(resp), .disable_i(disable_i),
    .pass_o(a_pass), .fail_o(a_fail), .overflow_o(a_ov), .pending_o(a_pend),
    .pass_total_o(a_tp), .fail_total_o(a_tf));

  sva_window_monitor #(.MIN_DLY(1), .MAX_DLY(10), .DEPTH(4), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .trig(trig), .resp(resp), .disable_i(disable_i),
    .pass_o(b_pass), .fail_o(b_fail), .overflow_o(b_ov), .pending_o(b_pend),
    .pass_total_o(b_tp), .fail_total_o(b_tf));

  sva_window_monitor #(.MIN_DLY(3), .MAX_DLY(5), .DEPTH(2), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .trig(trig), .resp(resp), .disable_i(disable_i),
    .pass_o(c_pass), .fail_o(c_fail), .overflow_o(c_ov), .pending_o(c_pend),
    .pass_total_o(c_tp), .fail_total_o(c_tf));

  int n_chk = 0;
  int n_fail = 0;

  // Model: each live attempt is just the edge number it started on.
  int ecnt;
  bit m_prev;
  int st [2][16];
  int n_att [2];
  int e_pass [2];
  int e_fail [2];
  int e_ov [2];
  int e_tp [2];
  int e_tf [2];

  // Snapshots of instance A (and B total) after each edge of a directed run.
  int s_pass [64];
  int s_fail [64];
  int s_ov [64];
  int s_pend [64];
  int s_tp [64];
  int s_tf [64];
  int s_btp [64];

  logic [63:0] tm, rm, dm;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    ecnt = 0;
    m_prev = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_att[i] = 0; e_pass[i] = 0; e_fail[i] = 0; e_ov[i] = 0; e_tp[i] = 0; e_tf[i] = 0;
    end
  endtask

  task automatic model_step();
    bit rose;
    int mn, mx, dp, k, age;
    ecnt++;
    rose = trig && !m_prev;
    for (int i = 0; i < 2; i++) begin
      mn = (i == 0) ? 1 : 3;
      mx = (i == 0) ? 10 : 5;
      dp = (i == 0) ? 4 : 2;
      e_pass[i] = 0; e_fail[i] = 0; e_ov[i] = 0;
      if (disable_i) begin
        n_att[i] = 0;
      end else begin
        k = 0;
        for (int j = 0; j < n_att[i]; j++) begin
          age = ecnt - st[i][j];
          if (resp && age >= mn) e_pass[i]++;
          else if (age == mx) e_fail[i]++;
          else begin st[i][k] = st[i][j]; k++; end
        end
        n_att[i] = k;
        if (rose) begin
          if (n_att[i] < dp) begin st[i][n_att[i]] = ecnt; n_att[i]++; end
          else e_ov[i] = 1;
        end
        e_tp[i] += e_pass[i];
        e_tf[i] += e_fail[i];
      end
    end
    m_prev = trig;
  endtask

  task automatic compare_all();
    chk("a_pass", a_pass, e_pass[0]);   chk("a_fail", a_fail, e_fail[0]);
    chk("a_ovf", a_ov, e_ov[0]);        chk("a_pend", a_pend, n_att[0]);
    chk("a_ptot", a_tp, sat(e_tp[0], 16)); chk("a_ftot", a_tf, sat(e_tf[0], 16));
    chk("b_pass", b_pass, e_pass[0]);   chk("b_fail", b_fail, e_fail[0]);
    chk("b_ovf", b_ov, e_ov[0]);        chk("b_pend", b_pend, n_att[0]);
    chk("b_ptot", b_tp, sat(e_tp[0], 2)); chk("b_ftot", b_tf, sat(e_tf[0], 2));
    chk("c_pass", c_pass, e_pass[1]);   chk("c_fail", c_fail, e_fail[1]);
    chk("c_ovf", c_ov, e_ov[1]);        chk("c_pend", c_pend, n_att[1]);
    chk("c_ptot", c_tp, sat(e_tp[1], 8)); chk("c_ftot", c_tf, sat(e_tf[1], 8));
  endtask

  // Called on a negedge; inputs apply to the next posedge, outputs are checked on the following negedge.
  task automatic tick(input logic t, input logic r, input logic d);
    trig = t; resp = r; disable_i = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    if (ecnt < 64) begin
      s_pass[ecnt] = a_pass; s_fail[ecnt] = a_fail; s_ov[ecnt] = a_ov;
      s_pend[ecnt] = a_pend; s_tp[ecnt] = a_tp; s_tf[ecnt] = a_tf; s_btp[ecnt] = b_tp;
    end
  endtask

  // Asserted off-edge so the asynchronous clear is observed before any clock.
  task automatic do_reset();
    trig = 1'b0; resp = 1'b0; disable_i = 1'b0;
    #2 rst = 1'b1;
    #1 model_reset();
    compare_all();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_seq(input int n);
    do_reset();
    for (int e = 1; e <= n; e++) tick(tm[e], rm[e], dm[e]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    model_reset();
    @(negedge clk);

    // Single attempt pass.
    tm = '0; rm = '0; dm = '0; tm[5] = 1'b1; rm[8] = 1'b1;
    run_seq(20);
    chk("t1_pend_e7", s_pend[7], 1);
    chk("t1_pass_e8", s_pass[8], 1);
    chk("t1_ptot_e8", s_tp[8], 1);
    chk("t1_pend_e8", s_pend[8], 0);
    chk("t1_ftot_end", s_tf[20], 0);

    // Resp only outside the window.
    tm = '0; rm = '0; dm = '0; tm[5] = 1'b1; rm[5] = 1'b1; rm[16] = 1'b1;
    run_seq(18);
    chk("t2_fail_e14", s_fail[14], 0);
    chk("t2_fail_e15", s_fail[15], 1);
    chk("t2_ftot_e15", s_tf[15], 1);
    chk("t2_ptot_end", s_tp[18], 0);

    // Overlapping attempts share one resp pulse.
    tm = '0; rm = '0; dm = '0; tm[2] = 1'b1; tm[4] = 1'b1; rm[6] = 1'b1; rm[7] = 1'b1;
    run_seq(10);
    chk("t3_pass_e6", s_pass[6], 2);
    chk("t3_pass_e7", s_pass[7], 0);
    chk("t3_ptot_e7", s_tp[7], 2);

    // Overflow with all four slots busy.
    tm = '0; rm = '0; dm = '0;
    for (int e = 2; e <= 10; e += 2) tm[e] = 1'b1;
    run_seq(22);
    chk("t4_ovf_e8", s_ov[8], 0);
    chk("t4_ovf_e10", s_ov[10], 1);
    chk("t4_pend_e10", s_pend[10], 4);
    chk("t4_fail_e12", s_fail[12], 1);
    chk("t4_fail_e18", s_fail[18], 1);
    chk("t4_ftot_e18", s_tf[18], 4);
    chk("t4_ftot_end", s_tf[22], 4);

    // Disable mid-flight.
    tm = '0; rm = '0; dm = '0; tm[3] = 1'b1; dm[6] = 1'b1;
    run_seq(16);
    chk("t5_pend_e5", s_pend[5], 1);
    chk("t5_pend_e6", s_pend[6], 0);
    chk("t5_fail_e13", s_fail[13], 0);
    chk("t5_ftot_end", s_tf[16], 0);

    // Reset with two attempts pending.
    tm = '0; rm = '0; dm = '0; tm[2] = 1'b1; tm[4] = 1'b1;
    run_seq(6);
    chk("t6_pend_pre", s_pend[6], 2);
    tm = '0;
    run_seq(15);
    chk("t6_ftot_end", s_tf[15], 0);
    chk("t6_pend_end", s_pend[15], 0);

    // Saturation of the 2-bit totals.
    tm = '0; rm = '0; dm = '0;
    for (int e = 2; e <= 10; e += 2) begin tm[e] = 1'b1; rm[e+1] = 1'b1; end
    run_seq(12);
    chk("t7_a_ptot", s_tp[12], 5);
    chk("t7_b_ptot", s_btp[12], 3);

    // Randomized traffic with varying response density.
    do_reset();
    for (int it = 0; it < 3000; it++) begin
      int rth;
      rth = ((it / 500) % 3 == 0) ? 1 : (((it / 500) % 3 == 1) ? 3 : 7);
      if ($urandom_range(0, 399) == 0) do_reset();
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) < rth), 1'($urandom_range(0, 49) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
